// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Sweeps an external 3-input combinational function through all eight input
// combinations, captures its output into an 8-bit truth table, counts the
// ones, then presents every minterm index (Y=1 entries) on a valid/ready
// stream in ascending order.
//
// Parameters
//   SETTLE     extra cycles {B,C,D} are held before Y is sampled (0..15)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   start      request a full sweep (only honoured in IDLE)
//   b, c, d    drive the external function, b is the index MSB
//   y          output of the external function
//   table_out  captured truth table, bit i = Y at index i
//   count      number of indices with Y=1 (0..8)
//   m_valid    a minterm index is being presented
//   m_index    minterm index being presented
//   m_ready    consumer accepts the minterm
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int unsigned SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       y,
    output logic [7:0] table_out,
    output logic [3:0] count,
    output logic       m_valid,
    output logic [2:0] m_index,
    input  logic       m_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;         // index currently driven onto {B,C,D}
    logic [2:0] p;           // EMIT scan pointer
    logic [3:0] settle_cnt;  // remaining hold cycles for the current index

    // Last DRIVE cycle of the current index: Y is captured at this edge.
    logic sample_now;
    // The EMIT entry at p is finished this cycle: either it is a zero
    // (skipped) or it is a one and the consumer takes it.
    logic emit_step;

    assign sample_now = (state == DRIVE) && (settle_cnt == 4'd0);
    assign emit_step  = (state == EMIT) && (!table_out[p] || m_ready);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = DRIVE;
            DRIVE: if (sample_now && idx == 3'd7) state_nxt = EMIT;
            EMIT:  if (emit_step && p == 3'd7) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: index, settle counter, table, count, scan pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 3'd0;
            p          <= 3'd0;
            settle_cnt <= 4'd0;
            table_out  <= 8'd0;
            count      <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        table_out  <= 8'd0;
                        count      <= 4'd0;
                        idx        <= 3'd0;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        table_out[idx] <= y;
                        count          <= count + {3'd0, y};
                        if (idx != 3'd7) begin
                            idx        <= idx + 3'd1;
                            settle_cnt <= SETTLE_LD;
                        end else begin
                            p <= 3'd0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                EMIT: begin
                    // p stops at 7 so the pointer never wraps back to 0;
                    // the state change to DONE ends the scan instead.
                    if (emit_step && p != 3'd7) begin
                        p <= p + 3'd1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // {B,C,D} follow idx directly: idx only changes in DRIVE (and on start or
    // reset), so outside DRIVE the function inputs keep their last value.
    always_comb begin
        {b, c, d} = idx;
        m_valid   = (state == EMIT) && table_out[p];
        m_index   = p;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Two scanners: dut0 with SETTLE=0 and dut1 with SETTLE=3. Each drives a
// bench-side truth-table function. Expected minterm indices go into a
// per-DUT queue when a sweep is started; a monitor pops and compares on every
// m_valid && m_ready handshake.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1;
    logic       m_ready0, m_ready1;
    logic       b0, c0, d0, b1, c1, d1;
    logic       y0, y1;
    logic [7:0] tbl0, tbl1;
    logic [3:0] cnt0, cnt1;
    logic       mv0, mv1;
    logic [2:0] mi0, mi1;
    logic       busy0, busy1, done0, done1;

    // External combinational functions, given as truth tables.
    logic [7:0] func0, func1;
    assign y0 = func0[{b0, c0, d0}];
    assign y1 = func1[{b1, c1, d1}];

    truth_table_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .b(b0), .c(c0), .d(d0), .y(y0),
        .table_out(tbl0), .count(cnt0),
        .m_valid(mv0), .m_index(mi0), .m_ready(m_ready0),
        .busy(busy0), .done(done0)
    );

    truth_table_scanner #(.SETTLE(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .b(b1), .c(c1), .d(d1), .y(y1),
        .table_out(tbl1), .count(cnt1),
        .m_valid(mv1), .m_index(mi1), .m_ready(m_ready1),
        .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int q0[$];
    int q1[$];
    int done_cnt0  = 0;
    int done_cnt1  = 0;
    int done_cyc0  = 0;
    int done_cyc1  = 0;
    int valid_cnt0 = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: sample away from the rising edge.
    always @(negedge clk) begin
        if (mv0) valid_cnt0++;
        if (mv0 && m_ready0) begin
            check("q0_entry_available", (q0.size() != 0) ? 1 : 0, 1);
            if (q0.size() != 0) check("m_index0", int'(mi0), q0.pop_front());
        end
        if (done0) begin
            done_cnt0++;
            done_cyc0 = cyc;
        end
        if (mv1 && m_ready1) begin
            check("q1_entry_available", (q1.size() != 0) ? 1 : 0, 1);
            if (q1.size() != 0) check("m_index1", int'(mi1), q1.pop_front());
        end
        if (done1) begin
            done_cnt1++;
            done_cyc1 = cyc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the next edge is the start edge.
    // s is the cycle counter value during the first cycle after that edge.
    task automatic pulse_start(input int which, output int s);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        s = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n0;
        int i;
        n0 = (which == 0) ? done_cnt0 : done_cnt1;
        i  = 0;
        while (i < budget && ((which == 0) ? done_cnt0 : done_cnt1) == n0) begin
            @(negedge clk);
            i++;
        end
        check((which == 0) ? "done0_seen" : "done1_seen",
              (((which == 0) ? done_cnt0 : done_cnt1) != n0) ? 1 : 0, 1);
        tick();
    endtask

    task automatic push_table(input int which, input logic [7:0] t);
        for (int i = 0; i < 8; i++) begin
            if (t[i]) begin
                if (which == 0) q0.push_back(i); else q1.push_back(i);
            end
        end
    endtask

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int d;
        int v;
        bit found;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        m_ready0 = 1'b1; m_ready1 = 1'b1;
        func0 = 8'h00; func1 = 8'h00;
        repeat (2) tick();
        rst = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rst_table", int'(tbl0), 0);
        check("rst_count", int'(cnt0), 0);
        check("rst_bcd",   int'({b0, c0, d0}), 0);
        check("rst_busy",  int'(busy0), 0);
        check("rst_done",  int'(done0), 0);
        check("rst_valid", int'(mv0), 0);
        check("rst_index", int'(mi0), 0);
        tick();

        // ---- scenario 1: minterms 1,5,7, ready always high ----
        func0 = 8'hA2;
        push_table(0, 8'hA2);
        d = done_cnt0;
        pulse_start(0, s);
        wait_done(0, 100);
        // cycle 1 is the first cycle after the start edge: 8 DRIVE + 8 EMIT,
        // DONE in cycle 17.
        check("s1_done_cycle", done_cyc0 - s + 1, 17);
        check("s1_table", int'(tbl0), 'hA2);
        check("s1_count", int'(cnt0), 3);
        repeat (2) tick();
        check("s1_done_pulses", done_cnt0 - d, 1);
        check("s1_q_drained", q0.size(), 0);

        // ---- scenario 3: back-pressure while index 5 is shown ----
        push_table(0, 8'hA2);
        pulse_start(0, s);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mv0 && mi0 == 3'd5) found = 1'b1;
            else tick();
        end
        check("s3_index5_shown", int'(found), 1);
        m_ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_stall_valid", int'(mv0), 1);
            check("s3_stall_index", int'(mi0), 5);
            tick();
        end
        m_ready0 = 1'b1;
        wait_done(0, 100);
        check("s3_table", int'(tbl0), 'hA2);
        check("s3_q_drained", q0.size(), 0);

        // ---- scenario 4a: Y tied to 0 ----
        func0 = 8'h00;
        d = done_cnt0;
        v = valid_cnt0;
        pulse_start(0, s);
        wait_done(0, 100);
        check("s4_zero_count", int'(cnt0), 0);
        check("s4_zero_table", int'(tbl0), 0);
        check("s4_zero_done_cycle", done_cyc0 - s + 1, 17);
        repeat (2) tick();
        check("s4_zero_valids", valid_cnt0 - v, 0);
        check("s4_zero_done_pulses", done_cnt0 - d, 1);

        // ---- scenario 4b: Y tied to 1 ----
        func0 = 8'hFF;
        push_table(0, 8'hFF);
        pulse_start(0, s);
        wait_done(0, 100);
        check("s4_ones_count", int'(cnt0), 8);
        check("s4_ones_table", int'(tbl0), 'hFF);
        check("s4_ones_q_drained", q0.size(), 0);

        // ---- scenario 5: start held high ----
        // Edge 0 starts sweep 1 (DONE in cycle 17, IDLE in cycle 18), edge 18
        // starts sweep 2, start drops before edge 36 so no third sweep.
        func0 = 8'hA2;
        push_table(0, 8'hA2);
        push_table(0, 8'hA2);
        d = done_cnt0;
        start0 = 1'b1;
        tick();
        s = cyc;
        repeat (18) tick();
        start0 = 1'b0;
        wait_done(0, 100);
        check("s5_second_done_cycle", done_cyc0 - s + 1, 35);
        repeat (5) tick();
        check("s5_done_pulses", done_cnt0 - d, 2);
        check("s5_idle_after", int'(busy0), 0);
        check("s5_q_drained", q0.size(), 0);

        // ---- scenario 2: SETTLE=3 on dut1 ----
        func1 = 8'hA2;
        push_table(1, 8'hA2);
        pulse_start(1, s);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check("s2_bcd", int'({b1, c1, d1}), (k - 1) / 4);
            check("s2_busy", int'(busy1), 1);
            if (k == 32) check("s2_table_before_last", int'(tbl1), 'h22);
        end
        @(negedge clk);
        check("s2_table_after_sweep", int'(tbl1), 'hA2);
        check("s2_bcd_hold", int'({b1, c1, d1}), 7);
        wait_done(1, 100);
        check("s2_count", int'(cnt1), 3);
        check("s2_q_drained", q1.size(), 0);

        // ---- scenario 6: reset at idx=4 in DRIVE, then a fresh run ----
        func0 = 8'hA2;
        d = done_cnt0;
        pulse_start(0, s);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if ({b0, c0, d0} == 3'd4) found = 1'b1;
        end
        check("s6_idx4_reached", int'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("s6_rst_table", int'(tbl0), 0);
        check("s6_rst_count", int'(cnt0), 0);
        check("s6_rst_bcd",   int'({b0, c0, d0}), 0);
        check("s6_rst_busy",  int'(busy0), 0);
        check("s6_rst_valid", int'(mv0), 0);
        check("s6_rst_done",  int'(done0), 0);
        tick();
        repeat (20) tick();
        check("s6_no_done_after_abort", done_cnt0 - d, 0);
        func0 = 8'h3C;
        push_table(0, 8'h3C);
        pulse_start(0, s);
        wait_done(0, 100);
        check("s6_table", int'(tbl0), 'h3C);
        check("s6_count", int'(cnt0), 4);
        check("s6_done_pulses", done_cnt0 - d, 1);
        check("s6_q_drained", q0.size(), 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 0, the number of extra cycles the {B,C,D} inputs are held before Y is sampled (legal range 0..15).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a full sweep; sampled only in IDLE.
REQ-006 B, C, D  output  1 each  drive the inputs of an external combinational 3-input function; B is the MSB of the index.
REQ-007 Y  input  1  output of that external function.
REQ-008 table_out  output  8  captured truth table; bit i = Y observed at index {B,C,D}=i.
REQ-009 count  output  4  number of indices with Y=1 (0..8).
REQ-010 m_valid  output  1  a minterm index is presented.
REQ-011 m_index  output  3  minterm index being presented.
REQ-012 m_ready  input  1  consumer accepts the minterm.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, DRIVE, EMIT and DONE.
REQ-016 IDLE with start=1 SHALL do the following at the next edge: clear table_out and count, set idx=0, drive {B,C,D}=0, load the settle counter with SETTLE, and enter DRIVE.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 {B,C,D} SHALL equal idx throughout DRIVE; in IDLE, EMIT and DONE they SHALL hold their last value.
REQ-019 DRIVE SHALL last exactly SETTLE+1 cycles per index.
REQ-020 At the edge ending the last DRIVE cycle of an index, the block SHALL write Y into table_out[idx] and increment count if Y=1.
REQ-021 After that write, if idx<7 the block SHALL increment idx, reload the settle counter and stay in DRIVE; if idx=7 it SHALL enter EMIT with scan pointer p=0.
REQ-022 A full sweep SHALL take 8*(SETTLE+1) cycles.
REQ-023 In EMIT with table_out[p]=0: m_valid SHALL be 0, and p SHALL advance by one per cycle.
REQ-024 In EMIT with table_out[p]=1: m_valid SHALL be 1 and m_index SHALL be p, both held stable until m_valid and m_ready are both high at an edge; p SHALL then advance.
REQ-025 m_ready SHALL be ignored while m_valid=0.
REQ-026 When p=7 has been skipped or handshaked, the block SHALL enter DONE; it SHALL NOT wrap p back to 0.
REQ-027 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-028 table_out and count SHALL hold their values until the next accepted start.
REQ-029 A table of all zeros SHALL produce no m_valid pulses and reach DONE after 8 EMIT cycles.
REQ-030 A table of all ones SHALL produce 8 handshakes and count=8; count SHALL be 4 bits wide so that it cannot overflow.
REQ-031 m_valid SHALL be 0 in IDLE, DRIVE and DONE.

Reset
REQ-032 rst=1 SHALL force the following at the next edge, overriding all other inputs including start: state=IDLE; B=C=D=0; table_out=0; count=0; m_valid=0; m_index=0; busy=0; done=0; idx=0; p=0; settle counter=0.
REQ-033 rst asserted mid-sweep or mid-EMIT SHALL abandon the operation with no done pulse and no further m_valid.
REQ-034 After rst deasserts, the block SHALL accept a new start normally.

Verification
REQ-035 Scenario 1: SETTLE=0; external function with minterms 1,5,7; start for 1 cycle; m_ready=1 throughout -> table_out=8'hA2, count=3, m_index sequence 1,5,7, done high exactly 17 cycles after the start edge.
REQ-036 Scenario 2: SETTLE=3; same function -> {B,C,D} steps 0..7 holding each value 4 cycles, sweep lasts 32 cycles, table_out=8'hA2.
REQ-037 Scenario 3: table 8'hA2; m_ready=0 for 5 cycles while m_index=5 is shown -> m_valid stays 1 and m_index stays 5 for all 5 cycles, no index is lost or duplicated, final sequence is 1,5,7.
REQ-038 Scenario 4: Y tied to 0 -> count=0, m_valid never asserts, done pulses once; Y tied to 1 -> count=8, indices 0..7 emitted in order.
REQ-039 Scenario 5: start held high continuously -> exactly one sweep per IDLE visit, and start is ignored while busy=1.
REQ-040 Scenario 6: rst at idx=4 in DRIVE, then a new start -> all outputs are 0 the cycle after rst, no done pulse from the aborted run, and the new run completes with a correct table_out.
